l2_arbiter: RTL

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/l2_arbiter.sv
// Round-robin arbiter that gives the icache or the dcache ownership of one shared L2 port.
// Includes an abort path when the owner's request drops, and a sticky watchdog that closes grants held too long.
module l2_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] l2_addr_ic,
    input  logic              drq,
    input  logic [ADDR_W-1:0] l2_addr_dc,
    input  logic              l2_cache_rw_dc,
    input  logic [DATA_W-1:0] rd_to_l2,
    input  logic              l2_rdy,
    input  logic              l2_complete,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rw,
    output logic [DATA_W-1:0] l2_wd,
    output logic              ic_gnt,
    output logic              dc_gnt,
    output logic              ic_done,
    output logic              dc_done,
    output logic              l2_timeout
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;
    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;

    // The watchdog fires in the last permitted grant cycle, so the grant never exceeds TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d, state_n_s;
    owner_t     owner_q, owner_d, last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic       own_req_s, busy_s, wd_hit_s, served_s, abort_s;

    assign own_req_s = (owner_q == OWN_DC) ? drq : irq;
    assign busy_s    = (state_q != ST_IDLE);
    assign wd_hit_s  = busy_s && (cnt_q == TMO_LAST);

    // Next-state, owner, watchdog and fairness bookkeeping.
    always_comb begin
        state_n_s = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        served_s  = 1'b0;
        abort_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (irq && drq) begin
                    owner_d   = (last_q == OWN_IC) ? OWN_DC : OWN_IC;
                    state_n_s = ST_REQ;
                end else if (irq) begin
                    owner_d   = OWN_IC;
                    state_n_s = ST_REQ;
                end else if (drq) begin
                    owner_d   = OWN_DC;
                    state_n_s = ST_REQ;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (!own_req_s) begin
                    abort_s   = 1'b1;
                    state_n_s = ST_IDLE;
                end else if (l2_rdy && l2_complete) begin
                    served_s  = 1'b1;
                    state_n_s = ST_IDLE;
                end else if (l2_rdy) begin
                    state_n_s = ST_WAIT;
                end else begin
                    state_n_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (l2_complete) begin
                    served_s  = 1'b1;
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
        state_d = wd_hit_s ? ST_IDLE : state_n_s;
        last_d  = (served_s || (wd_hit_s && !abort_s)) ? owner_q : last_q;
        tmo_d   = tmo_q | wd_hit_s;
    end

    // State registers; reset leaves the first tie to the dcache.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IC;
            last_q  <= OWN_IC;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ic_gnt     = busy_s && (owner_q == OWN_IC);
    assign dc_gnt     = busy_s && (owner_q == OWN_DC);
    assign l2_req     = (state_q == ST_REQ) && own_req_s;
    assign ic_done    = l2_complete && ic_gnt;
    assign dc_done    = l2_complete && dc_gnt;
    assign l2_timeout = tmo_q;

    // Request-path mux; the icache only ever reads.
    always_comb begin
        l2_addr = {ADDR_W{1'b0}};
        l2_rw   = 1'b0;
        l2_wd   = {DATA_W{1'b0}};
        if (!busy_s) begin
            l2_addr = {ADDR_W{1'b0}};
        end else if (owner_q == OWN_DC) begin
            l2_addr = l2_addr_dc;
            l2_rw   = l2_cache_rw_dc;
            l2_wd   = rd_to_l2;
        end else begin
            l2_addr = l2_addr_ic;
        end
    end

endmodule
